csa_accum: RTL and testbench
============================

# csa_accum

Pipelined, parametrised carry-save accumulator for the MAC datapath. Each accepted beat delivers `LANES` operands of `N` bits, which are folded into a redundant sum/carry register pair through a chain of 3:2 compressor rows, so no carry propagates per beat. On the packet's last beat, one carry-propagate add resolves the total. The result is presented on a valid/ready output port together with the packet's beat count.

## Interface
- `N`, default 32: operand and result width; all arithmetic is modulo 2^N.
- `LANES`, default 2: operands per beat, minimum 1.
- `CNT_W`, default 8: width of the beat counter, which saturates.
- `clk` in 1: clock; the only clock; rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_data` in `LANES*N`: operands; lane k is `in_data[k*N +: N]`.
- `in_last` in 1: the beat is the last beat of the packet.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_sum` out `N`: sum of all operands in the packet, mod 2^N.
- `out_count` out `CNT_W`: beats in the packet, saturating at 2^CNT_W−1.

## Operation
- **State machine** with states `ACCUM`, `RESOLVE`, `OUTPUT`. Reset state is `ACCUM`.
- **Beat accepted** when `in_valid && in_ready`.
- **`in_ready`** is 1 only in `ACCUM` (a combinational decode of the state).
  - It reads 1 while `rst` is high.
  - No beat is ever accepted while `rst` is high.
- **Accumulator registers:** `acc_ps` and `acc_pc`, `N` bits each; both reset to 0.
- **Compression:** operands `{acc_ps, acc_pc<<1, lane0 … lane(LANES−1)}` are compressed by `LANES` cascaded 3:2 rows.
  - Every carry vector is shifted left by 1 before entering the next row.
  - The bit shifted out of the MSB is discarded (mod 2^N).
  - The final row's sum and carry are registered into `acc_ps`/`acc_pc`.
  - The stored `acc_pc` is unshifted; the shift is applied on the next use.
- **Beat counter** `cnt`:
  - Increments on each accepted beat, saturating at all-ones.
  - The value loaded into `out_count` includes the last beat.
- **Transitions:**
  - `ACCUM` → `RESOLVE` on an accepted beat with `in_last=1`. That beat is still accumulated.
  - `RESOLVE` → `OUTPUT` unconditionally. On this edge: `out_sum` ← `acc_ps + (acc_pc<<1)` mod 2^N, `out_count` ← `cnt`, `out_valid` ← 1.
  - `OUTPUT` → `ACCUM` on `out_valid && out_ready`. On the same edge: `acc_ps`, `acc_pc` and `cnt` clear to 0, and `out_valid` ← 0.
- **Output hold:** `out_sum` and `out_count` hold their values after the handshake until the next result is loaded.
- **Idle:** `in_valid` low in `ACCUM` leaves all state unchanged. The `in_data` and `in_last` values are don't-care when there is no handshake.
- **Unsigned vs. signed:** identical behaviour (two's-complement wrap).

## Timing
- **Reset values:** `out_valid`=0, `out_sum`=0, `out_count`=0; state is `ACCUM`, so `in_ready`=1.
- **Throughput:** one beat per cycle while in `ACCUM`.
- **Latency:** last beat accepted at edge t → state is `RESOLVE` in cycle t+1 → `out_valid`=1 from edge t+2.
- **Minimum packet cycle:** one input beat plus 2 cycles plus the handshake cycle. `in_ready` returns to 1 in the cycle after the output handshake.
- **Backpressure:** `out_valid` and the output data stay stable until `out_ready`. `in_ready` stays 0 throughout.
- **Reset mid-packet:** asynchronous. The partial sum and count are discarded; there is no output for that packet.
- **`in_last` on the first beat:** a single-beat packet, with `out_count`=1.

## Structure
- **Shared package** `mac_pkg`:
  - Enum `csa_acc_state_t` (`ACCUM`, `RESOLVE`, `OUTPUT`).
  - Localparams for the default `N`, `LANES` and `CNT_W`.
- **Sub-module** `csa_row #(N)`:
  - One 3:2 compressor row: bitwise full adders, outputs sum and raw carry.
  - Instantiated `LANES` times in a generate loop.
  - The inter-row shift is done in `csa_accum`.
- **Final adder:** the CPA is a plain `+` in `csa_accum`.

## Test plan
- **Single beat:** one beat, lanes (1, 2), `in_last`=1 → `out_valid` two edges after acceptance, `out_sum`=3, `out_count`=1.
- **Multi-beat:** three back-to-back beats (0x10, 0x20), (5, 5), (1, 0), last on the third beat → `out_sum`=0x3B, `out_count`=3, `in_ready` low from the edge after the last beat.
- **Wrap-around:** with N=16, beats (0xFFFF, 0x0002), (0x8000, 0x8000) → `out_sum`=0x0001, and no X or extra bit on `out_sum`.
- **Output backpressure:**
  - Hold `out_ready` low 5 cycles → `out_sum` and `out_count` stable and `in_ready`=0 throughout.
  - After the handshake, `in_ready`=1 on the next cycle.
  - Next packet (7, 0), last on its only beat → `out_sum`=7, proving the accumulator cleared.
- **Reset mid-packet:** send 2 non-last beats, assert `rst` asynchronously mid-cycle → all outputs 0 immediately. Then packet (4, 4), last on its only beat → `out_sum`=8, `out_count`=1.
- **Saturation and stalls:** with CNT_W=2, send 5 beats of (1, 1) with random `in_valid` gaps → `out_sum`=10, `out_count`=3.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared types and default parameters for the MAC datapath blocks.
//   csa_acc_state_t : csa_accum control states (ACCUM, RESOLVE, OUTPUT)
//   CSA_N / CSA_LANES / CSA_CNT_W : default operand width, lanes per beat, counter width
package mac_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } csa_acc_state_t;

  localparam int unsigned CSA_N     = 32;
  localparam int unsigned CSA_LANES = 2;
  localparam int unsigned CSA_CNT_W = 8;

endpackage

// File: rtl/csa_accum_if.sv
// csa_accum_if: beat input and result output handshakes of csa_accum.
//   in_valid/in_ready/in_data/in_last : operand beats, LANES lanes of N bits
//   out_valid/out_ready/out_sum/out_count : packet result and beat count
// Modports: master = traffic source/sink, slave = the accumulator.
interface csa_accum_if
  import mac_pkg::*;
#(
  parameter int unsigned N     = CSA_N,
  parameter int unsigned LANES = CSA_LANES,
  parameter int unsigned CNT_W = CSA_CNT_W
) ();

  logic               in_valid;
  logic               in_ready;
  logic [LANES*N-1:0] in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       out_sum;
  logic [CNT_W-1:0]   out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );

endinterface

// File: rtl/csa_row.sv
// csa_row: one 3:2 compressor row of N independent full adders.
//   a, b, c : operand vectors
//   sum     : bitwise sum
//   carry   : raw (unshifted) carry; the caller applies the weight shift
module csa_row #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  always_comb begin
    sum   = a ^ b ^ c;
    carry = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/csa_accum.sv
// csa_accum: carry-save accumulator. Each accepted beat of LANES operands is folded
// into a redundant sum/carry pair with no carry propagation; the packet total is
// resolved by one carry-propagate add after the last beat.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of csa_accum_if (beat input, result output with beat count)
module csa_accum
  import mac_pkg::*;
#(
  parameter int unsigned N     = CSA_N,
  parameter int unsigned LANES = CSA_LANES,
  parameter int unsigned CNT_W = CSA_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  csa_accum_if.slave  bus
);

  csa_acc_state_t state_q, state_d;

  logic [N-1:0]     acc_ps_q, acc_pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic [N-1:0]     out_sum_q;
  logic [CNT_W-1:0] out_count_q;

  logic in_ready;
  logic accept;
  logic out_hs;

  // Row k compresses {ps_chain[k], pc_chain[k], lane k}; pc_chain carries are pre-shifted.
  logic [LANES:0][N-1:0]   ps_chain;
  logic [LANES-1:0][N-1:0] pc_chain;
  logic [LANES-1:0][N-1:0] carry_raw;

  assign ps_chain[0] = acc_ps_q;
  assign pc_chain[0] = acc_pc_q << 1;

  for (genvar k = 0; k < int'(LANES); k++) begin : g_row
    csa_row #(
      .N (N)
    ) u_row (
      .a     (ps_chain[k]),
      .b     (pc_chain[k]),
      .c     (bus.in_data[k*N +: N]),
      .sum   (ps_chain[k+1]),
      .carry (carry_raw[k])
    );
    if (k + 1 < int'(LANES)) begin : g_shift
      assign pc_chain[k+1] = carry_raw[k] << 1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (accept && bus.in_last) state_d = RESOLVE;
      RESOLVE: state_d = OUTPUT;
      OUTPUT:  if (out_hs) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // State decode
  always_comb begin
    in_ready = (state_q == ACCUM);
    accept   = bus.in_valid && in_ready;
    out_hs   = out_valid_q && bus.out_ready;
  end

  // Datapath. accept (ACCUM) and out_hs (OUTPUT) never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_ps_q    <= '0;
      acc_pc_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else begin
      if (accept) begin
        acc_ps_q <= ps_chain[LANES];
        // Stored unshifted; the weight shift is applied where it is consumed.
        acc_pc_q <= carry_raw[LANES-1];
        cnt_q    <= (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      end
      if (state_q == RESOLVE) begin
        out_sum_q   <= acc_ps_q + (acc_pc_q << 1);
        out_count_q <= cnt_q;
        out_valid_q <= 1'b1;
      end
      if (out_hs) begin
        acc_ps_q    <= '0;
        acc_pc_q    <= '0;
        cnt_q       <= '0;
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_csa_accum.sv
// tb_csa_accum: directed bench for csa_accum. Two instances run in lockstep on the same
// stimulus: A with defaults (N=32, CNT_W=8) and B with N=16, CNT_W=2, so wrap-around and
// counter saturation are checked against both widths.
module tb_csa_accum;

  logic clk;
  logic rst;

  int unsigned n_cmp;
  int unsigned n_bad;

  csa_accum_if #(.N(32), .LANES(2), .CNT_W(8)) bus_a ();
  csa_accum_if #(.N(16), .LANES(2), .CNT_W(2)) bus_b ();

  csa_accum #(.N(32), .LANES(2), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  csa_accum #(.N(16), .LANES(2), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] a0, input logic [31:0] a1,
                        input logic last);
    bus_a.in_valid = v;
    bus_a.in_data  = {a1, a0};
    bus_a.in_last  = last;
    bus_b.in_valid = v;
    bus_b.in_data  = {a1[15:0], a0[15:0]};
    bus_b.in_last  = last;
  endtask

  task automatic set_ready(input logic r);
    bus_a.out_ready = r;
    bus_b.out_ready = r;
  endtask

  // One accepted beat; in_ready must be high before the edge.
  task automatic send(input logic [31:0] a0, input logic [31:0] a1, input logic last);
    set_in(1'b1, a0, a1, last);
    chk("beat_rdy_a", bus_a.in_ready, 1);
    chk("beat_rdy_b", bus_b.in_ready, 1);
    tick();
    set_in(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
  endtask

  // Called one cycle after the last beat: expects RESOLVE, then the result, then handshake.
  task automatic take_result(input string tag, input logic [63:0] sa, input logic [63:0] ca,
                             input logic [63:0] sb, input logic [63:0] cb);
    chk({tag, "_rdy_lo_a"}, bus_a.in_ready, 0);
    chk({tag, "_rdy_lo_b"}, bus_b.in_ready, 0);
    chk({tag, "_vld_lo"}, bus_a.out_valid, 0);
    tick();
    chk({tag, "_vld_a"}, bus_a.out_valid, 1);
    chk({tag, "_vld_b"}, bus_b.out_valid, 1);
    chk({tag, "_sum_a"}, bus_a.out_sum, sa);
    chk({tag, "_cnt_a"}, bus_a.out_count, ca);
    chk({tag, "_sum_b"}, bus_b.out_sum, sb);
    chk({tag, "_cnt_b"}, bus_b.out_count, cb);
    set_ready(1'b1);
    tick();
    set_ready(1'b0);
    chk({tag, "_vld_clr_a"}, bus_a.out_valid, 0);
    chk({tag, "_vld_clr_b"}, bus_b.out_valid, 0);
    chk({tag, "_rdy_back"}, bus_a.in_ready, 1);
    chk({tag, "_hold_a"}, bus_a.out_sum, sa);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    set_in(1'b0, 32'h0, 32'h0, 1'b0);
    set_ready(1'b0);

    // Reset values, sampled while rst is still high
    #2;
    chk("rst_rdy_a", bus_a.in_ready, 1);
    chk("rst_rdy_b", bus_b.in_ready, 1);
    chk("rst_vld_a", bus_a.out_valid, 0);
    chk("rst_sum_a", bus_a.out_sum, 0);
    chk("rst_cnt_a", bus_a.out_count, 0);
    chk("rst_vld_b", bus_b.out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single beat
    send(32'd1, 32'd2, 1'b1);
    take_result("single", 3, 1, 3, 1);

    // Multi-beat, back to back
    send(32'h10, 32'h20, 1'b0);
    send(32'd5, 32'd5, 1'b0);
    send(32'd1, 32'd0, 1'b1);
    take_result("multi", 64'h3B, 3, 64'h3B, 3);

    // Wrap-around: 0x20001 at 32 bits, 0x0001 at 16 bits
    send(32'hFFFF, 32'h0002, 1'b0);
    send(32'h8000, 32'h8000, 1'b1);
    chk("wrap_pre_vld", bus_b.out_valid, 0);
    tick();
    chk("wrap_sum_a", bus_a.out_sum, 64'h20001);
    chk("wrap_sum_b", bus_b.out_sum, 64'h0001);
    chk("wrap_nox_b", {63'b0, $isunknown(bus_b.out_sum)}, 0);
    chk("wrap_cnt_b", bus_b.out_count, 2);
    set_ready(1'b1);
    tick();
    set_ready(1'b0);
    chk("wrap_vld_clr", bus_b.out_valid, 0);

    // Output backpressure
    send(32'h1234, 32'h10, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld_a", bus_a.out_valid, 1);
      chk("bp_sum_a", bus_a.out_sum, 64'h1244);
      chk("bp_cnt_a", bus_a.out_count, 1);
      chk("bp_sum_b", bus_b.out_sum, 64'h1244);
      chk("bp_rdy_a", bus_a.in_ready, 0);
      chk("bp_rdy_b", bus_b.in_ready, 0);
      tick();
    end
    set_ready(1'b1);
    tick();
    set_ready(1'b0);
    chk("bp_vld_clr", bus_a.out_valid, 0);
    chk("bp_rdy_back_a", bus_a.in_ready, 1);
    chk("bp_rdy_back_b", bus_b.in_ready, 1);
    send(32'd7, 32'd0, 1'b1);
    take_result("after_bp", 7, 1, 7, 1);

    // Reset mid-packet: partial sum and count dropped, outputs cleared at once
    send(32'd3, 32'd3, 1'b0);
    send(32'd3, 32'd3, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_vld_a", bus_a.out_valid, 0);
    chk("mrst_sum_a", bus_a.out_sum, 0);
    chk("mrst_cnt_a", bus_a.out_count, 0);
    chk("mrst_sum_b", bus_b.out_sum, 0);
    chk("mrst_rdy_a", bus_a.in_ready, 1);
    #2;
    rst = 1'b0;
    tick();
    send(32'd4, 32'd4, 1'b1);
    take_result("post_rst", 8, 1, 8, 1);

    // Saturation with idle gaps carrying junk data
    for (int i = 0; i < 5; i++) begin
      int unsigned gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < int'(gaps); g++) begin
        chk("gap_rdy", bus_b.in_ready, 1);
        tick();
      end
      send(32'd1, 32'd1, (i == 4));
    end
    take_result("sat", 10, 5, 10, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
